// File: rtl/fa_64bit_seq_if.sv
// Operand/result handshake bundle for the chunk-serial 64-bit adder.
// Ovf and its modport entries exist only when FA_OVF_EN is defined.
interface fa_64bit_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef FA_OVF_EN
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
`endif
endinterface

// File: rtl/fa_64bit_seq.sv
// Chunk-serial adder: Sum = A + B + Cin, one CHUNK-bit slice per cycle with a registered carry.
// Define FA_OVF_EN to add the signed-overflow output Ovf.
module fa_64bit_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic           clk,
  input logic           rst_n,
  fa_64bit_seq_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             out_valid_r;
  logic             in_ready_r;
`ifdef FA_OVF_EN
  logic             ovf_r;
`endif

  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice;

  // One slice of the carry chain, selected by the slice counter from the latched operands.
  always_comb begin
    base  = BW'(cnt) * BW'(CHUNK);
    a_sl  = a_l[base +: CHUNK];
    b_sl  = b_l[base +: CHUNK];
    slice = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_l         <= '0;
      b_l         <= '0;
      carry_reg   <= 1'b0;
      cnt         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
`ifdef FA_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_l        <= bus.A;
            b_l        <= bus.B;
            carry_reg  <= bus.Cin;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_r[base +: CHUNK] <= slice[CHUNK-1:0];
          carry_reg            <= slice[CHUNK];
          // The counter parks on the last slice rather than wrapping.
          if (cnt == LAST) begin
            cout_r      <= slice[CHUNK];
`ifdef FA_OVF_EN
            ovf_r       <= (a_l[WIDTH-1] == b_l[WIDTH-1]) &&
                           (slice[CHUNK-1] != a_l[WIDTH-1]);
`endif
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Sum       = sum_r;
  assign bus.Cout      = cout_r;
`ifdef FA_OVF_EN
  assign bus.Ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_fa_64bit_seq.sv
// Scoreboard bench for fa_64bit_seq: a CHUNK=16 instance and a CHUNK=8 instance on one clock.
// Overflow vectors are exercised only when FA_OVF_EN is defined.
module tb_fa_64bit_seq;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q16[$];
  exp_t q8[$];

  fa_64bit_seq_if #(.WIDTH(64)) bus ();
  fa_64bit_seq_if #(.WIDTH(64)) bus8 ();

  fa_64bit_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  fa_64bit_seq #(.WIDTH(64), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; monitors sample on the falling edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel, input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input bit push, input logic [63:0] es,
                               input logic ec, input logic eo);
    bit   ok;
    bit   accepted;
    exp_t e;
    accepted = 1'b0;
    if (sel) begin
      bus8.in_valid = 1'b1; bus8.A = a; bus8.B = b; bus8.Cin = cin;
    end else begin
      bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.Cin = cin;
    end
    for (int n = 0; n < 50; n++) begin
      ok = sel ? bus8.in_ready : bus.in_ready;
      waitCycle();
      if (ok) begin
        accepted = 1'b1;
        break;
      end
    end
    if (sel) bus8.in_valid = 1'b0;
    else     bus.in_valid  = 1'b0;
    checkOutput("accept", {63'd0, accepted}, 64'd1);
    if (push) begin
      e.sum = es; e.cout = ec; e.ovf = eo;
      if (sel) q8.push_back(e);
      else     q16.push_back(e);
    end
  endtask

  task automatic checkLatency(input bit sel, input int expCycles);
    int cycles;
    cycles = 0;
    while (!(sel ? bus8.out_valid : bus.out_valid) && cycles < 20) begin
      waitCycle();
      cycles++;
    end
    checkOutput(sel ? "latency_chunk8" : "latency_chunk16", 64'(cycles), 64'(expCycles));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (q16.size() == 0) begin
        checkOutput("unexpected_result16", 64'd1, 64'd0);
      end else begin
        e = q16.pop_front();
        checkOutput("sum16", bus.Sum, e.sum);
        checkOutput("cout16", {63'd0, bus.Cout}, {63'd0, e.cout});
`ifdef FA_OVF_EN
        checkOutput("ovf16", {63'd0, bus.Ovf}, {63'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected_result8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("sum8", bus8.Sum, e.sum);
        checkOutput("cout8", {63'd0, bus8.Cout}, {63'd0, e.cout});
`ifdef FA_OVF_EN
        checkOutput("ovf8", {63'd0, bus8.Ovf}, {63'd0, e.ovf});
`endif
      end
    end
  end

  initial begin
    int drain;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.A = '0;  bus.B = '0;  bus.Cin = 1'b0;  bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0; bus8.out_ready = 1'b1;
    waitCycle();
    waitCycle();
    checkOutput("reset_sum", bus.Sum, 64'd0);
    checkOutput("reset_cout", {63'd0, bus.Cout}, 64'd0);
    checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;
    waitCycle();

    // Vector 1: carries ripple across two of the four slice boundaries.
    applyStimulus(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b1,
                  64'hBBBB_DDDE_0000_2221, 1'b0, 1'b0);
    checkLatency(1'b0, 4);
    waitCycle();

    // Vector 2: full ripple through every slice.
    applyStimulus(1'b0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                  64'h0000_0000_0000_0001, 1'b1, 1'b0);
    checkLatency(1'b0, 4);
    waitCycle();

    // Backpressure: result must hold while new operands are offered.
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b1,
                  64'hBBBB_DDDE_0000_2221, 1'b0, 1'b0);
    checkLatency(1'b0, 4);
    bus.in_valid = 1'b1;
    bus.A = 64'h0000_0000_0000_0001;
    bus.B = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.Cin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      waitCycle();
      checkOutput("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("hold_sum", bus.Sum, 64'hBBBB_DDDE_0000_2221);
      checkOutput("hold_cout", {63'd0, bus.Cout}, 64'd0);
      checkOutput("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    waitCycle();
    checkOutput("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
    bus.in_valid = 1'b0;
    waitCycle();
    checkOutput("no_overlap_accept", {63'd0, bus.in_ready}, 64'd1);

    // Abort: reset during the second RUN cycle discards the operation.
    applyStimulus(1'b0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                  64'd0, 1'b0, 1'b0);
    waitCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sum", bus.Sum, 64'd0);
    checkOutput("abort_cout", {63'd0, bus.Cout}, 64'd0);
    checkOutput("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    waitCycle();
    rst_n = 1'b1;
    waitCycle();
    applyStimulus(1'b0, 64'd5, 64'd3, 1'b0, 1'b1, 64'd8, 1'b0, 1'b0);
    checkLatency(1'b0, 4);
    waitCycle();

`ifdef FA_OVF_EN
    applyStimulus(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1);
    checkLatency(1'b0, 4);
    waitCycle();
    applyStimulus(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
                  64'd0, 1'b1, 1'b1);
    checkLatency(1'b0, 4);
    waitCycle();
`endif

    // Eight-slice instance: latency follows the slice count.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);
    checkLatency(1'b1, 8);
    waitCycle();

    drain = 0;
    while ((q16.size() + q8.size()) != 0 && drain < 50) begin
      waitCycle();
      drain++;
    end
    checkOutput("scoreboard_drain", 64'(q16.size() + q8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
